// File: rtl/audio_tone_scheduler.sv
// Fixed-priority, non-preemptive tone arbiter for the I2S speaker path.
// Square-wave samples update only on synchronized lrclk frame ticks.
module audio_tone_scheduler #(
  parameter int NREQ       = 3,
  parameter int PW         = 20,
  parameter int DW         = 16,
  parameter int GAP_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lrclk,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] half_period,
  input  logic [NREQ*16-1:0] volume,
  input  logic [NREQ*DW-1:0] duration,
  input  logic [NREQ*2-1:0]  pan,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [15:0]        lChannel,
  output logic [15:0]        rChannel
);

  localparam int GW = (GAP_FRAMES > 1) ?
                      $clog2(GAP_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  state_t          state;
  logic            lr_s1;
  logic            lr_s2;
  logic            lr_d;
  logic            tick;
  logic [PW-1:0]   act_hp;
  logic [14:0]     act_vol;
  logic [DW-1:0]   act_dur;
  logic [1:0]      act_pan;
  logic [PW-1:0]   phase;
  logic            pol;
  logic [DW-1:0]   frames;
  logic [GW-1:0]   gap_cnt;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   sel_hp;
  logic [14:0]     sel_vol;
  logic [DW-1:0]   sel_dur;
  logic [1:0]      sel_pan;
  logic [NREQ-1:0] unused_vol_msb;

  logic [15:0]     amp;
  logic [15:0]     tone;
  logic [15:0]     l_next;
  logic [15:0]     r_next;
  logic            end_a;
  logic            end_b;

  // Falling edge of the synchronized lrclk marks a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_d  <= 1'b0;
    end else begin
      lr_s1 <= lrclk;
      lr_s2 <= lr_s1;
      lr_d  <= lr_s2;
    end
  end

  assign tick = lr_d & ~lr_s2;

  // Descending scan leaves the lowest set index as winner.
  always_comb begin
    pick    = '0;
    sel_hp  = '0;
    sel_vol = '0;
    sel_dur = '0;
    sel_pan = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
        sel_hp  = half_period[i*PW +: PW];
        sel_vol = volume[i*16 +: 15];
        sel_dur = duration[i*DW +: DW];
        sel_pan = pan[i*2 +: 2];
      end
    end
  end

  always_comb begin
    unused_vol_msb = '0;
    for (int i = 0; i < NREQ; i++) begin
      unused_vol_msb[i] = volume[i*16 + 15];
    end
  end

  assign amp  = {1'b0, act_vol};
  assign tone = (state != PLAY) ? 16'h0000 :
                pol ? amp : -amp;

  always_comb begin
    l_next = tone;
    r_next = tone;
    unique case (act_pan)
      2'b00: begin
        l_next = tone;
        r_next = tone;
      end
      2'b01: begin
        l_next = tone;
        r_next = 16'h0000;
      end
      2'b10: begin
        l_next = 16'h0000;
        r_next = tone;
      end
      2'b11: begin
        l_next = tone;
        r_next = -tone;
      end
    endcase
  end

  assign end_a = (act_dur != '0) && tick &&
                 (frames == act_dur - DW'(1));
  assign end_b = ~|(req & gnt);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= '0;
      lChannel <= '0;
      rChannel <= '0;
      act_hp   <= '0;
      act_vol  <= '0;
      act_dur  <= '0;
      act_pan  <= '0;
      phase    <= '0;
      pol      <= 1'b0;
      frames   <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= '0;
      if (tick) begin
        lChannel <= l_next;
        rChannel <= r_next;
      end
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= pick;
            act_hp  <= sel_hp;
            act_vol <= sel_vol;
            act_dur <= sel_dur;
            act_pan <= sel_pan;
            pol     <= 1'b1;
            phase   <= '0;
            frames  <= '0;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (act_hp != '0) begin
            if (phase == act_hp - PW'(1)) begin
              phase <= '0;
              pol   <= ~pol;
            end else begin
              phase <= phase + PW'(1);
            end
          end
          if (tick) begin
            frames <= frames + DW'(1);
          end
          if (end_a || end_b) begin
            gnt     <= '0;
            done    <= gnt;
            gap_cnt <= '0;
            if (GAP_FRAMES == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GW'(GAP_FRAMES - 1)) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_tone_scheduler.sv
// Directed bench for audio_tone_scheduler.
// Expected channel samples go through a scoreboard queue.
module tb_audio_tone_scheduler;

  localparam int NREQ = 3;
  localparam int PW   = 20;
  localparam int DW   = 16;

  logic               clk;
  logic               rst_n;
  logic               lrclk;
  logic [NREQ-1:0]    req;
  logic [NREQ*PW-1:0] half_period;
  logic [NREQ*16-1:0] volume;
  logic [NREQ*DW-1:0] duration;
  logic [NREQ*2-1:0]  pan;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [15:0]        lChannel;
  logic [15:0]        rChannel;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] sb[$];
  logic gnt_both = 1'b0;

  audio_tone_scheduler #(
    .NREQ(NREQ),
    .PW(PW),
    .DW(DW),
    .GAP_FRAMES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lrclk(lrclk),
    .req(req),
    .half_period(half_period),
    .volume(volume),
    .duration(duration),
    .pan(pan),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .lChannel(lChannel),
    .rChannel(rChannel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-clk frame, offset from clk edges.
  initial begin
    lrclk = 1'b1;
    #3;
    forever #640 lrclk = ~lrclk;
  end

  always @(negedge clk) begin
    if (gnt == 3'b110) gnt_both <= 1'b1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sbq"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(tag, {lChannel, rChannel}, e);
    end
  endtask

  // Returns a few clocks after the DUT registered a frame tick.
  task automatic next_frame();
    @(negedge lrclk);
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done != '0) break;
    end
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic set_req(input int i,
                         input logic [PW-1:0] hp,
                         input logic [15:0] vol,
                         input logic [DW-1:0] dur,
                         input logic [1:0] p);
    half_period[i*PW +: PW] = hp;
    volume[i*16 +: 16]      = vol;
    duration[i*DW +: DW]    = dur;
    pan[i*2 +: 2]           = p;
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = '0;
    half_period = '0;
    volume      = '0;
    duration    = '0;
    pan         = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_done", {29'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lr", {lChannel, rChannel}, 32'd0);
    rst_n = 1'b1;

    // 1: single tone, three frames, alternating polarity
    next_frame();
    set_req(0, 20'd128, 16'h1000, 16'd3, 2'b00);
    req = 3'b001;
    @(negedge clk);
    check("t1_gnt", {29'd0, gnt}, 32'h1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    sb.push_back({16'h1000, 16'h1000});
    sb.push_back({16'hF000, 16'hF000});
    sb.push_back({16'h1000, 16'h1000});
    next_frame();
    sb_check("t1_s0");
    next_frame();
    sb_check("t1_s1");
    wait_done(300);
    check("t1_done", {29'd0, done}, 32'h1);
    check("t1_gnt_off", {29'd0, gnt}, 32'h0);
    sb_check("t1_s2");
    req = 3'b000;
    @(negedge clk);
    check("t1_done_pulse", {29'd0, done}, 32'h0);
    for (int f = 0; f < 4; f++) begin
      sb.push_back(32'd0);
      next_frame();
      sb_check("t1_gap");
      if (f == 2) check("t1_busy_gap", {31'd0, busy}, 32'd1);
    end
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: two requests at once, priority and gap
    set_req(1, 20'd0, 16'h0400, 16'd2, 2'b00);
    set_req(2, 20'd0, 16'h0300, 16'd0, 2'b00);
    req = 3'b110;
    @(negedge clk);
    check("t2_gnt1", {29'd0, gnt}, 32'h2);
    sb.push_back({16'h0400, 16'h0400});
    sb.push_back({16'h0400, 16'h0400});
    next_frame();
    sb_check("t2_s0");
    wait_done(300);
    check("t2_done1", {29'd0, done}, 32'h2);
    sb_check("t2_s1");
    req = 3'b100;
    n = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      n++;
      if (gnt != '0) break;
    end
    check("t2_gnt2", {29'd0, gnt}, 32'h4);
    check("t2_gap_len", {31'd0, (n >= 505 && n <= 520)}, 32'd1);
    sb.push_back({16'h0300, 16'h0300});
    next_frame();
    sb_check("t2_s2");
    req = 3'b000;
    @(negedge clk);
    check("t2_done2", {29'd0, done}, 32'h4);
    check("t2_never_110", {31'd0, gnt_both}, 32'd0);
    wait_idle(1000);

    // 3: endless tone ended by dropping req mid-frame
    set_req(0, 20'd0, 16'h2000, 16'd0, 2'b00);
    req = 3'b001;
    @(negedge clk);
    check("t3_gnt", {29'd0, gnt}, 32'h1);
    sb.push_back({16'h2000, 16'h2000});
    next_frame();
    sb_check("t3_s0");
    repeat (30) @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    check("t3_gnt_off", {29'd0, gnt}, 32'h0);
    check("t3_done", {29'd0, done}, 32'h1);
    @(negedge clk);
    check("t3_done_pulse", {29'd0, done}, 32'h0);
    check("t3_hold", {lChannel, rChannel},
          {16'h2000, 16'h2000});
    sb.push_back(32'd0);
    next_frame();
    sb_check("t3_zero");
    wait_idle(1000);

    // 4: full-scale volume, inverted right, then left only
    set_req(0, 20'd0, 16'hFFFF, 16'd0, 2'b11);
    req = 3'b001;
    @(negedge clk);
    check("t4_gnt", {29'd0, gnt}, 32'h1);
    sb.push_back({16'h7FFF, 16'h8001});
    sb.push_back({16'h7FFF, 16'h8001});
    next_frame();
    sb_check("t4_inv0");
    next_frame();
    sb_check("t4_inv1");
    req = 3'b000;
    wait_idle(1000);
    set_req(0, 20'd0, 16'hFFFF, 16'd0, 2'b01);
    req = 3'b001;
    sb.push_back({16'h7FFF, 16'h0000});
    next_frame();
    sb_check("t4_left");

    // 5: asynchronous reset while playing
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt", {29'd0, gnt}, 32'h0);
    check("t5_done", {29'd0, done}, 32'h0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_lr", {lChannel, rChannel}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_regnt", {29'd0, gnt}, 32'h1);
    check("t5_busy2", {31'd0, busy}, 32'd1);
    req = 3'b000;
    wait_idle(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
